// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drain-side consumer for a synchronous FIFO.
// It pops one byte at a time whenever the FIFO is non-empty and shifts it
// out as a UART frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
// All outputs come straight from flops.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,        // asynchronous, active-low
    input  logic       fifo_empty,
    input  logic [7:0] read_data,
    output logic       read_enable,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    // Bit-period counter width; a 1-bit floor keeps the vector legal at the minimum.
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    // Last cycle of a bit period, and the cycle before it.
    // tx_done is raised on the cycle before the last so that it is high
    // exactly during the final cycle of the stop bit.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             r_read_enable;
    logic             r_busy;
    logic             r_tx_done;

    logic             w_bit_end;
    logic             w_last_bit;
    logic [CNT_W-1:0] w_cnt_inc;

    // End of the current bit period and the last data bit.
    assign w_bit_end  = (r_clk_cnt == CNT_LAST);
    assign w_last_bit = (r_bit_idx == 3'd7);
    assign w_cnt_inc  = r_clk_cnt + CNT_W'(1);

    // Frame sequencer with registered outputs: pop, load, then start/data/stop bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_clk_cnt     <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_tx          <= 1'b1;
            r_read_enable <= 1'b0;
            r_busy        <= 1'b0;
            r_tx_done     <= 1'b0;
        end else begin
            // Pulse outputs default low; only a single state raises each one.
            r_read_enable <= 1'b0;
            r_tx_done     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // The empty flag is looked at here and nowhere else.
                    r_tx      <= 1'b1;
                    r_busy    <= 1'b0;
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    if (!fifo_empty) begin
                        r_state       <= S_POP;
                        r_read_enable <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end

                S_POP: begin
                    // read_enable is high during this state only; the FIFO
                    // presents the byte during the following state.
                    r_state <= S_LOAD;
                end

                S_LOAD: begin
                    r_shift   <= read_data;
                    r_tx      <= 1'b0;
                    r_clk_cnt <= '0;
                    r_state   <= S_START;
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_clk_cnt <= w_cnt_inc;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        // Shift right; the next bit to send is currently at [1].
                        r_clk_cnt <= '0;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        r_shift   <= {1'b0, r_shift[7:1]};
                        if (w_last_bit) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_tx <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= w_cnt_inc;
                    end
                end

                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_clk_cnt <= w_cnt_inc;
                        if (r_clk_cnt == CNT_PRE) begin
                            r_tx_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign read_enable = r_read_enable;
    assign tx          = r_tx;
    assign busy        = r_busy;
    assign tx_done     = r_tx_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed testbench for fifo_uart_tx with a behavioural synchronous FIFO
// on its read port and a frame decoder watching the serial line.
module tb_fifo_uart_tx;

    localparam int C     = 4;
    localparam int FRAME = 10 * C;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] read_data  = 8'h00;
    logic       read_enable;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .read_data  (read_data),
        .read_enable(read_enable),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    // Behavioural sync FIFO: registered read data, registered empty flag.
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] fq[$];
    int         pop_err = 0;

    initial forever begin
        @(posedge clk);
        if (read_enable) begin
            if (fq.size() > 0) read_data <= fq.pop_front();
            else pop_err++;
        end
        if (wr_en) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
    end

    // Line monitor: pulse counters and a frame decoder sampling every cycle.
    int         cyc = 0, re_cnt = 0, done_cnt = 0, re_err = 0, frame_err = 0;
    logic       prev_tx = 1'b1, prev_re = 1'b0;
    logic [7:0] rx_q[$];
    int         start_q[$];
    logic       smp[FRAME];
    bit         in_frame = 1'b0;
    bit         bad;
    int         pos = 0, s_cyc = 0;
    logic [7:0] dec;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (read_enable === 1'b1) begin
            re_cnt++;
            if (prev_re === 1'b1) re_err++;
        end
        if (tx_done === 1'b1) done_cnt++;
        if (!reset) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (tx === 1'b0 && prev_tx === 1'b1) begin
                in_frame = 1'b1;
                s_cyc    = cyc;
                smp[0]   = tx;
                pos      = 1;
            end
        end else begin
            smp[pos] = tx;
            pos++;
            if (pos == FRAME) begin
                bad = 1'b0;
                for (int k = 0; k < 10; k++)
                    for (int j = 1; j < C; j++)
                        if (smp[k*C+j] !== smp[k*C]) bad = 1'b1;
                if (smp[0] !== 1'b0 || smp[9*C] !== 1'b1) bad = 1'b1;
                for (int i = 0; i < 8; i++) dec[i] = smp[(i+1)*C];
                if (bad) frame_err++;
                rx_q.push_back(dec);
                start_q.push_back(s_cyc);
                $display("[%0d] frame decoded: 0x%02h start_cycle=%0d", cyc, dec, s_cyc);
                in_frame = 1'b0;
            end
        end
        prev_tx = tx;
        prev_re = read_enable;
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else n_pass++;
        n_checks++; if (read_enable !== 1'b0) $display("FAIL reset_re: got %b want 0", read_enable); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (tx_done !== 1'b0) $display("FAIL reset_done: got %b want 0", tx_done); else n_pass++;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        $display("[%0d] reset applied and released", cyc);
    endtask

    task automatic test_empty();
        int re0 = re_cnt;
        int tx_bad = 0, busy_bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_bad++;
            if (busy !== 1'b0) busy_bad++;
        end
        n_checks++; if (re_cnt != re0) $display("FAIL empty_re: got %0d pulses want 0", re_cnt - re0); else n_pass++;
        n_checks++; if (tx_bad != 0) $display("FAIL empty_tx: got %0d non-idle cycles want 0", tx_bad); else n_pass++;
        n_checks++; if (busy_bad != 0) $display("FAIL empty_busy: got %0d busy cycles want 0", busy_bad); else n_pass++;
        $display("[%0d] empty fifo held 200 cycles", cyc);
    endtask

    task automatic test_single_byte();
        logic [9:0] fr = {1'b1, 8'hCA, 1'b0};
        int re0 = re_cnt, d0 = done_cnt, rx0 = rx_q.size(), fe0 = frame_err;
        int bit_bad, done_bad;
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'hCA;
        @(negedge clk);
        wr_en = 1'b0;
        n_checks++; if (read_enable !== 1'b0 || busy !== 1'b0) $display("FAIL single_pre: re=%b busy=%b want 0,0", read_enable, busy); else n_pass++;
        @(negedge clk);
        n_checks++; if (read_enable !== 1'b1 || busy !== 1'b1) $display("FAIL single_pop: re=%b busy=%b want 1,1", read_enable, busy); else n_pass++;
        @(negedge clk);
        n_checks++; if (read_enable !== 1'b0 || tx !== 1'b1) $display("FAIL single_load: re=%b tx=%b want 0,1", read_enable, tx); else n_pass++;
        done_bad = 0;
        for (int k = 0; k < 10; k++) begin
            bit_bad = 0;
            for (int j = 0; j < C; j++) begin
                @(negedge clk);
                if (tx !== fr[k]) bit_bad++;
                if (tx_done !== ((k == 9 && j == C-1) ? 1'b1 : 1'b0)) done_bad++;
            end
            n_checks++; if (bit_bad != 0) $display("FAIL single_bit%0d: got tx=%b want %b", k, tx, fr[k]); else n_pass++;
        end
        n_checks++; if (done_bad != 0) $display("FAIL single_done_timing: got %0d bad cycles want 0", done_bad); else n_pass++;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || tx !== 1'b1 || tx_done !== 1'b0) $display("FAIL single_idle: busy=%b tx=%b done=%b want 0,1,0", busy, tx, tx_done); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (re_cnt - re0 != 1) $display("FAIL single_re_cnt: got %0d want 1", re_cnt - re0); else n_pass++;
        n_checks++; if (done_cnt - d0 != 1) $display("FAIL single_done_cnt: got %0d want 1", done_cnt - d0); else n_pass++;
        n_checks++;
        if (rx_q.size() != rx0 + 1) $display("FAIL single_rx_count: got %0d want 1", rx_q.size() - rx0);
        else if (rx_q[rx0] !== 8'hCA || frame_err != fe0) $display("FAIL single_rx: got 0x%02h err=%0d want 0xca err=0", rx_q[rx0], frame_err - fe0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int re0 = re_cnt, d0 = done_cnt, rx0 = rx_q.size(), n = 0, gap;
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'hCA;
        @(negedge clk);
        wr_data = 8'hAA;
        @(negedge clk);
        wr_en = 1'b0;
        while (done_cnt < d0 + 2 && n < 3 * (FRAME + 10)) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        n_checks++; if (done_cnt - d0 != 2) $display("FAIL b2b_done: got %0d want 2", done_cnt - d0); else n_pass++;
        n_checks++; if (re_cnt - re0 != 2) $display("FAIL b2b_re_cnt: got %0d want 2", re_cnt - re0); else n_pass++;
        n_checks++;
        if (rx_q.size() < rx0 + 2) $display("FAIL b2b_rx_count: got %0d want 2", rx_q.size() - rx0);
        else if (rx_q[rx0] !== 8'hCA || rx_q[rx0+1] !== 8'hAA) $display("FAIL b2b_rx: got 0x%02h,0x%02h want 0xca,0xaa", rx_q[rx0], rx_q[rx0+1]);
        else n_pass++;
        gap = (start_q.size() >= rx0 + 2) ? (start_q[rx0+1] - start_q[rx0] - FRAME) : -1;
        n_checks++; if (gap != 3) $display("FAIL b2b_gap: got %0d want 3", gap); else n_pass++;
        n_checks++; if (fifo_empty !== 1'b1 || busy !== 1'b0) $display("FAIL b2b_idle: empty=%b busy=%b want 1,0", fifo_empty, busy); else n_pass++;
        n_checks++; if (re_err != 0 || pop_err != 0) $display("FAIL b2b_re_pulse: got re_err=%0d pop_err=%0d want 0,0", re_err, pop_err); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int n = 0, re0, d0, rx0, tx_low = 0, busy_hi = 0;
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'hCA;
        @(negedge clk);
        wr_en = 1'b0;
        while (tx !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        n_checks++; if (tx !== 1'b0) $display("FAIL mid_start: got tx=%b want 0", tx); else n_pass++;
        // Frame bit 4 is data bit 3; land in its middle.
        repeat (4 * C + 1) @(negedge clk);
        n_checks++; if (tx !== 1'b1 || busy !== 1'b1) $display("FAIL mid_bit3: tx=%b busy=%b want 1,1", tx, busy); else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++; if (tx !== 1'b1 || busy !== 1'b0 || read_enable !== 1'b0 || tx_done !== 1'b0)
            $display("FAIL mid_async: tx=%b busy=%b re=%b done=%b want 1,0,0,0", tx, busy, read_enable, tx_done);
        else n_pass++;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        re0 = re_cnt; d0 = done_cnt; rx0 = rx_q.size();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_low++;
            if (busy !== 1'b0) busy_hi++;
        end
        n_checks++; if (tx_low != 0 || busy_hi != 0) $display("FAIL mid_after: got tx_low=%0d busy=%0d want 0,0", tx_low, busy_hi); else n_pass++;
        n_checks++; if (re_cnt != re0 || done_cnt != d0 || rx_q.size() != rx0)
            $display("FAIL mid_no_frame: got re=%0d done=%0d rx=%0d want 0,0,0", re_cnt - re0, done_cnt - d0, rx_q.size() - rx0);
        else n_pass++;
        $display("[%0d] reset mid-frame recovered", cyc);
    endtask

    task automatic test_pop_count();
        logic [7:0] data[16];
        int re0 = re_cnt, d0 = done_cnt, rx0 = rx_q.size(), fe0 = frame_err, n = 0, gap_bad = 0;
        for (int i = 0; i < 16; i++) data[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_data = data[i];
        end
        @(negedge clk);
        wr_en = 1'b0;
        while (done_cnt < d0 + 16 && n < 16 * (FRAME + 3) + 100) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        n_checks++; if (re_cnt - re0 != 16) $display("FAIL pop_re_cnt: got %0d want 16", re_cnt - re0); else n_pass++;
        n_checks++; if (done_cnt - d0 != 16) $display("FAIL pop_done_cnt: got %0d want 16", done_cnt - d0); else n_pass++;
        n_checks++; if (rx_q.size() - rx0 != 16) $display("FAIL pop_rx_count: got %0d want 16", rx_q.size() - rx0); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (rx0 + i >= rx_q.size()) $display("FAIL pop_byte%0d: got none want 0x%02h", i, data[i]);
            else if (rx_q[rx0+i] !== data[i]) $display("FAIL pop_byte%0d: got 0x%02h want 0x%02h", i, rx_q[rx0+i], data[i]);
            else n_pass++;
        end
        for (int i = 1; i < 16; i++)
            if (rx0 + i < start_q.size() && start_q[rx0+i] - start_q[rx0+i-1] != FRAME + 3) gap_bad++;
        n_checks++; if (gap_bad != 0) $display("FAIL pop_gaps: got %0d bad gaps want 0", gap_bad); else n_pass++;
        n_checks++; if (frame_err != fe0 || pop_err != 0 || re_err != 0)
            $display("FAIL pop_integrity: got frame_err=%0d pop_err=%0d re_err=%0d want 0,0,0", frame_err - fe0, pop_err, re_err);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_empty();
        test_single_byte();
        test_back_to_back();
        test_reset_mid_frame();
        test_pop_count();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
